// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event queue.
//   KEY_W      : width of a key code {extend, scan code}
//   KEY_N      : size of the decoder's held-key vector
//   key_code_t : 9-bit key code
//   rpt_state_t: auto-repeat FSM states
//   cnt_w()    : width of a 0..depth occupancy counter
package kbd_pkg;

  localparam int unsigned KEY_W = 9;
  localparam int unsigned KEY_N = 512;

  typedef logic [KEY_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (discards all entries)
//   push, din : write request and data
//   pop       : remove head entry (ignored while empty)
//   dout      : head entry, valid while empty=0
//   empty/full: occupancy flags (registered)
//   count     : number of occupied entries (registered)
//   overflow  : one-cycle pulse when a push is dropped
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module key_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned WIDTH = KEY_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      empty,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;

  logic             w_do_pop;
  logic             w_do_push;
  logic [CNT_W-1:0] w_count_nxt;

  // Accept/reject decisions; a pop on a full queue frees the slot for a same-cycle push.
  always_comb begin
    w_do_pop    = pop & ~r_empty;
    w_do_push   = push & (~r_full | w_do_pop);
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Storage; cleared on reset so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == CNT_W'(DEPTH));
      r_overflow <= push & r_full & ~w_do_pop;
    end
  end

  assign dout     = r_mem[r_rd_ptr];
  assign empty    = r_empty;
  assign full     = r_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: rtl/key_event_queue.sv
// Key event queue with typematic auto-repeat.
// Converts PS/2 decoder events into a FWFT queue of 9-bit key codes and
// re-issues the most recently pressed key while it stays held.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   key_down    : held-key vector (already updated when key_valid fires)
//   last_change : code of the last decoder event
//   key_valid   : one-cycle decoder event strobe
//   pop         : consumer removes the head entry
//   head_code   : head entry, valid while empty=0
//   empty, full : queue flags
//   count       : occupied entries
//   overflow    : one-cycle pulse when a push is dropped
//   repeating   : auto-repeat FSM is in its repeat phase
module key_event_queue
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DELAY_CYC  = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KEY_N-1:0]        key_down,
  input  key_code_t               last_change,
  input  logic                    key_valid,
  input  logic                    pop,
  output key_code_t               head_code,
  output logic                    empty,
  output logic                    full,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    repeating
);

  localparam int unsigned MAX_CYC   = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
  localparam int unsigned RPT_CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [RPT_CNT_W-1:0] DELAY_LAST  = RPT_CNT_W'(DELAY_CYC - 1);
  localparam logic [RPT_CNT_W-1:0] REPEAT_LAST = RPT_CNT_W'(REPEAT_CYC - 1);

  rpt_state_t             r_state;
  key_code_t              r_held_code;
  logic [RPT_CNT_W-1:0]   r_cnt;
  logic                   r_repeating;

  rpt_state_t             w_state_nxt;
  key_code_t              w_held_nxt;
  logic [RPT_CNT_W-1:0]   w_cnt_nxt;
  logic                   w_rpt_push;

  logic                   w_evt_down;
  logic                   w_press;
  logic                   w_release;
  logic                   w_held_down;
  logic                   w_held_gone;
  logic [RPT_CNT_W-1:0]   w_cnt_last;

  logic                   w_push;
  key_code_t              w_push_code;

  // Event classification: key_down already reflects the event in the same cycle.
  always_comb begin
    w_evt_down  = key_down[last_change];
    w_press     = key_valid & w_evt_down;
    w_release   = key_valid & ~w_evt_down;
    w_held_down = key_down[r_held_code];
    w_held_gone = (w_release & (last_change == r_held_code)) | ~w_held_down;
    w_cnt_last  = (r_state == ST_DELAY) ? DELAY_LAST : REPEAT_LAST;
  end

  // Auto-repeat next-state logic; a press always restarts the delay phase.
  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held_code;
    w_cnt_nxt   = r_cnt;
    w_rpt_push  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt = ST_DELAY;
          w_held_nxt  = last_change;
          w_cnt_nxt   = '0;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (w_press) begin
          w_state_nxt = ST_DELAY;
          w_held_nxt  = last_change;
          w_cnt_nxt   = '0;
        end else if (w_held_gone) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == w_cnt_last) begin
          w_state_nxt = ST_REPEAT;
          w_cnt_nxt   = '0;
          w_rpt_push  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + RPT_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_held_code <= '0;
      r_cnt       <= '0;
      r_repeating <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_held_code <= w_held_nxt;
      r_cnt       <= w_cnt_nxt;
      r_repeating <= (w_state_nxt == ST_REPEAT);
    end
  end

  // Single push port: a press wins; the repeat push is only raised when no press occurred.
  always_comb begin
    w_push      = w_press | w_rpt_push;
    w_push_code = w_press ? last_change : r_held_code;
  end

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .din      (w_push_code),
    .pop      (pop),
    .dout     (head_code),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  assign repeating = r_repeating;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed table, hand-written corner sequences,
// and random traffic against a queue-based reference model.
module tb_key_event_queue;
  import kbd_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned D     = 8;
  localparam int unsigned R     = 4;
  localparam int unsigned CW    = cnt_w(DEPTH);

  logic            clk = 1'b0;
  logic            rst;
  logic [511:0]    kd;
  key_code_t       lc;
  logic            kv;
  logic            pp;
  key_code_t       head_code;
  logic            empty, full, overflow, repeating;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  key_event_queue #(
    .DEPTH      (DEPTH),
    .DELAY_CYC  (D),
    .REPEAT_CYC (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (kd),
    .last_change (lc),
    .key_valid   (kv),
    .pop         (pp),
    .head_code   (head_code),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .repeating   (repeating)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a queue plus "which key is held since which edge".
  key_code_t mq[$];
  bit        m_active;
  key_code_t m_held;
  int        m_t0;
  bit        m_ovf;
  int        edge_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_active = 1'b0;
    m_held   = '0;
    m_t0     = 0;
    m_ovf    = 1'b0;
  endfunction

  // One clock edge of the intended behaviour, using the inputs present before it.
  function automatic void model_tick();
    bit        press_e;
    bit        push_e;
    bit        pop_e;
    key_code_t pcode;
    int        n;
    press_e = kv && kd[lc];
    push_e  = 1'b0;
    pcode   = '0;
    if (press_e) begin
      push_e   = 1'b1;
      pcode    = lc;
      m_active = 1'b1;
      m_held   = lc;
      m_t0     = edge_n;
    end else if (m_active && !kd[m_held]) begin
      m_active = 1'b0;
    end else if (m_active) begin
      n = edge_n - m_t0;
      if (n >= int'(D) && ((n - int'(D)) % int'(R)) == 0) begin
        push_e = 1'b1;
        pcode  = m_held;
      end
    end
    pop_e = pp && (mq.size() > 0);
    m_ovf = 1'b0;
    if (pop_e) void'(mq.pop_front());
    if (push_e) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(pcode);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic check_model();
    bit rep;
    rep = m_active && ((edge_n - m_t0) >= int'(D));
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_full", 32'(full), 32'(mq.size() == int'(DEPTH)));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_repeating", 32'(repeating), 32'(rep));
    if (mq.size() > 0) chk("m_head", 32'(head_code), 32'(mq[0]));
  endtask

  // Inputs are set at the falling edge; one rising edge is taken and checked.
  task automatic step();
    @(posedge clk);
    edge_n++;
    model_tick();
    #1;
    check_model();
    @(negedge clk);
    kv = 1'b0;
    pp = 1'b0;
  endtask

  task automatic press_key(input key_code_t c);
    kd[c] = 1'b1; kv = 1'b1; lc = c;
  endtask

  task automatic release_key(input key_code_t c);
    kd[c] = 1'b0; kv = 1'b1; lc = c;
  endtask

  task automatic pop_expect(input key_code_t c);
    chk("pop_head", 32'(head_code), 32'(c));
    pp = 1'b1;
    step();
  endtask

  function automatic key_code_t pick_code();
    case ($urandom_range(0, 7))
      0: return 9'h01C;
      1: return 9'h01B;
      2: return 9'h11D;
      3: return 9'h023;
      4: return 9'h0F0;
      5: return 9'h1FF;
      6: return 9'h000;
      default: return 9'h175;
    endcase
  endfunction

  typedef struct {
    logic      kv;
    key_code_t code;
    logic      down;
    logic      pop;
    int        exp_count;
    key_code_t exp_head;
    logic      exp_full;
    logic      exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic k, input key_code_t c, input logic dn, input logic p,
                              input int ec, input key_code_t eh, input logic ef, input logic eo);
    vec_t v;
    v.kv = k; v.code = c; v.down = dn; v.pop = p;
    v.exp_count = ec; v.exp_head = eh; v.exp_full = ef; v.exp_ovf = eo;
    return v;
  endfunction

  initial begin
    vec_t tbl[10];
    key_code_t c;

    tbl[0] = mk(1, 9'h010, 1, 0, 1, 9'h010, 0, 0);
    tbl[1] = mk(1, 9'h011, 1, 0, 2, 9'h010, 0, 0);
    tbl[2] = mk(1, 9'h012, 1, 0, 3, 9'h010, 0, 0);
    tbl[3] = mk(1, 9'h013, 1, 0, 4, 9'h010, 1, 0);
    tbl[4] = mk(1, 9'h014, 1, 0, 4, 9'h010, 1, 1);
    tbl[5] = mk(1, 9'h015, 1, 1, 4, 9'h011, 1, 0);
    tbl[6] = mk(0, 9'h000, 0, 1, 3, 9'h012, 0, 0);
    tbl[7] = mk(0, 9'h000, 0, 1, 2, 9'h013, 0, 0);
    tbl[8] = mk(0, 9'h000, 0, 1, 1, 9'h015, 0, 0);
    tbl[9] = mk(0, 9'h000, 0, 1, 0, 9'h000, 0, 0);

    rst = 1'b1; kd = '0; lc = '0; kv = 1'b0; pp = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_head", 32'(head_code), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_repeating", 32'(repeating), 32'd0);

    // Hold 0x11D: entries land at offsets 0, 8, 12, 16 after the press edge
    for (int k = 0; k < 20; k++) begin
      if (k == 0) press_key(9'h11D);
      step();
      chk("hold_count", 32'(count), 32'(1 + int'(k >= 8) + int'(k >= 12) + int'(k >= 16)));
      chk("hold_repeating", 32'(repeating), 32'(k >= 8));
    end
    release_key(9'h11D);
    step();
    for (int i = 0; i < 4; i++) pop_expect(9'h11D);
    chk("hold_drained", 32'(empty), 32'd1);

    // Single tap: one entry, no repeats
    for (int k = 0; k < 16; k++) begin
      if (k == 0) press_key(9'h01C);
      if (k == 5) release_key(9'h01C);
      step();
    end
    chk("tap_count", 32'(count), 32'd1);
    chk("tap_head", 32'(head_code), 32'h01C);
    pop_expect(9'h01C);
    chk("tap_empty", 32'(empty), 32'd1);

    // Key switch: only the newest key repeats, first repeat 8 edges after its press
    for (int k = 0; k < 18; k++) begin
      if (k == 0) press_key(9'h01C);
      if (k == 5) press_key(9'h01B);
      if (k == 6) release_key(9'h01C);
      step();
      if (k == 12) chk("sw_count_k12", 32'(count), 32'd2);
      if (k == 13) chk("sw_count_k13", 32'(count), 32'd3);
      if (k == 17) chk("sw_count_k17", 32'(count), 32'd4);
    end
    release_key(9'h01B);
    step();
    pop_expect(9'h01C);
    pop_expect(9'h01B);
    pop_expect(9'h01B);
    pop_expect(9'h01B);
    chk("sw_empty", 32'(empty), 32'd1);

    // Table: fill, overflow, push+pop on full, drain
    for (int i = 0; i < 10; i++) begin
      kv = tbl[i].kv;
      lc = tbl[i].code;
      if (tbl[i].kv) kd[tbl[i].code] = tbl[i].down;
      pp = tbl[i].pop;
      step();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].exp_count == 0));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      if (tbl[i].exp_count > 0)
        chk($sformatf("tbl%0d_head", i), 32'(head_code), 32'(tbl[i].exp_head));
    end
    release_key(9'h015); step();
    for (int i = 0; i < 5; i++) begin
      release_key(key_code_t'(9'h010 + i));
      step();
    end

    // Reset mid-stream with 3 entries queued while repeating
    press_key(9'h030); step();
    press_key(9'h031); step();
    for (int k = 0; k < 8; k++) step();
    chk("mid_pre_count", 32'(count), 32'd3);
    chk("mid_pre_repeating", 32'(repeating), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_repeating", 32'(repeating), 32'd0);
    chk("mid_full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    release_key(9'h030); step();
    release_key(9'h031); step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        press_key(pick_code());
      end else if (r < 14) begin
        c = pick_code();
        release_key(c);
      end
      pp = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
